// File: rtl/fu_stage_pkg.sv
// Shared encodings for the external functional unit: opcodes, csr bit
// positions and the reserved register numbers also known to de_stage.
package fu_stage_pkg;

  typedef enum logic [2:0] {
    AOP_ADD  = 3'd0,
    AOP_SUB  = 3'd1,
    AOP_MUL  = 3'd2,
    AOP_DIVU = 3'd3,
    AOP_REMU = 3'd4
  } fu_aop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fu_state_e;

  localparam int CSR_BUSY = 0;
  localparam int CSR_DONE = 1;
  localparam int CSR_ERR  = 2;

  localparam int FU_REG_CSR   = 26;
  localparam int FU_REG_OP3   = 27;
  localparam int FU_REG_ALUOP = 29;
  localparam int FU_REG_OP1   = 30;
  localparam int FU_REG_OP2   = 31;

  function automatic logic [2:0] mk_csr(input logic err, input logic done, input logic busy);
    mk_csr = {err, done, busy};
  endfunction

  function automatic logic aop_legal(input logic [2:0] code);
    aop_legal = (code <= 3'd4);
  endfunction

endpackage

// File: rtl/fu_divider.sv
// Restoring unsigned divider: one load cycle on start, then DIV_BITS shift/subtract
// steps. done pulses for one cycle together with the final quotient/remainder.
module fu_divider #(
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted   = {rem, quo[31]};
  assign diff      = shifted - {1'b0, dvs};
  assign quotient  = quo;
  assign remainder = rem;

  // Load on start, then one restoring step per cycle until the step counter expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo  <= dividend;
        rem  <= '0;
        dvs  <= divisor;
        cnt  <= 6'(DIV_BITS);
        busy <= 1'b1;
      end else if (busy) begin
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= shifted[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fu_stage.sv
// External functional unit on the DE<->FU bus. Snoops WB writes to the reserved
// operand/opcode registers and presents {csr, op3} straight from registers.
//
// state | meaning
// IDLE  | no result since reset, operands writable
// BUSY  | operation in flight, operand and opcode writes ignored
// DONE  | result (or error) latched in op3/csr, operands writable
module fu_stage
  import fu_stage_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [70:0] from_DE_to_FU,
  output logic [34:0] from_FU_to_DE
);

  logic        wr_aluop;
  logic        wr_op1;
  logic        wr_op2;
  logic [31:0] regval;
  logic        is_rd_op3;
  logic        unused_bits;

  assign wr_aluop    = from_DE_to_FU[0];
  assign wr_op1      = from_DE_to_FU[1];
  assign wr_op2      = from_DE_to_FU[2];
  assign regval      = from_DE_to_FU[34:3];
  assign is_rd_op3   = from_DE_to_FU[35];
  assign unused_bits = ^from_DE_to_FU[70:36];

  fu_state_e   state;
  fu_aop_e     aluop;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op3;
  logic [2:0]  csr;
  logic [3:0]  cnt;
  logic [31:0] mul_lo;
  logic        start_ok;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign from_FU_to_DE = {csr, op3};
  assign mul_lo        = op1 * op2;

  // A legal start in IDLE/DONE; division by zero never launches the divider.
  assign start_ok  = (state != ST_BUSY) && wr_aluop && aop_legal(regval[2:0]);
  assign div_start = start_ok && (regval[2:0] == AOP_DIVU || regval[2:0] == AOP_REMU) &&
                     (op2 != 32'd0);

  fu_divider #(.DIV_BITS(DIV_BITS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (op1),
    .divisor   (op2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Control FSM with operand/result registers and the MUL latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      aluop <= AOP_ADD;
      op1   <= '0;
      op2   <= '0;
      op3   <= '0;
      csr   <= 3'b000;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (wr_aluop) begin
            if (aop_legal(regval[2:0])) begin
              aluop <= fu_aop_e'(regval[2:0]);
              cnt   <= 4'(MUL_LAT - 1);
              csr   <= mk_csr(1'b0, 1'b0, 1'b1);
              state <= ST_BUSY;
            end else begin
              csr   <= mk_csr(1'b1, 1'b1, 1'b0);
              state <= ST_DONE;
            end
          end else begin
            if (wr_op1) op1 <= regval;
            if (wr_op2) op2 <= regval;
          end
        end
        ST_BUSY: begin
          case (aluop)
            AOP_ADD, AOP_SUB: begin
              op3   <= (aluop == AOP_ADD) ? op1 + op2 : op1 - op2;
              csr   <= mk_csr(1'b0, 1'b1, 1'b0);
              state <= ST_DONE;
            end
            AOP_MUL: begin
              if (cnt == 4'd0) begin
                op3   <= mul_lo;
                csr   <= mk_csr(1'b0, 1'b1, 1'b0);
                state <= ST_DONE;
              end else begin
                cnt <= cnt - 4'd1;
              end
            end
            default: begin
              if (op2 == 32'd0) begin
                op3   <= (aluop == AOP_DIVU) ? 32'hFFFF_FFFF : op1;
                csr   <= mk_csr(1'b1, 1'b1, 1'b0);
                state <= ST_DONE;
              end else if (div_done) begin
                op3   <= (aluop == AOP_DIVU) ? div_q : div_r;
                csr   <= mk_csr(1'b0, 1'b1, 1'b0);
                state <= ST_DONE;
              end
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_one_wb_write: assert property (@(posedge clk) disable iff (reset)
    !(wr_aluop && (wr_op1 || wr_op2)));
  a_no_op3_read_busy: assert property (@(posedge clk) disable iff (reset)
    !(is_rd_op3 && csr[CSR_BUSY]));
  a_div_within_busy: assert property (@(posedge clk) disable iff (reset)
    !(div_busy && state != ST_BUSY));

endmodule

// File: tb/tb_fu_stage.sv
// Directed bench for fu_stage: stimulus pushes expected {csr, op3} plus the cycle
// at which the result must appear; a negedge monitor pops and compares.
module tb_fu_stage;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [70:0] from_DE_to_FU;
  logic [34:0] from_FU_to_DE;

  logic        wr_aluop = 1'b0;
  logic        wr_op1 = 1'b0;
  logic        wr_op2 = 1'b0;
  logic [31:0] regval = '0;
  logic        is_rd_op3 = 1'b0;

  assign from_DE_to_FU = {35'h0, is_rd_op3, regval, wr_op2, wr_op1, wr_aluop};

  fu_stage #(.MUL_LAT(MUL_LAT), .DIV_BITS(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .from_DE_to_FU (from_DE_to_FU),
    .from_FU_to_DE (from_FU_to_DE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [34:0] val;
    int          issue;
    int          due;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Result monitor: a settled, non-busy, done output after the issuing edge retires the head entry.
  always @(negedge clk) begin
    if (!reset && sb.size() > 0 && cyc > sb[0].issue &&
        from_FU_to_DE[32] == 1'b0 && from_FU_to_DE[33] == 1'b1) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, " value"}, 64'(from_FU_to_DE), 64'(e.val));
      check({e.name, " latency"}, 64'(cyc), 64'(e.due));
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic wb(input logic a, input logic o1, input logic o2, input logic [31:0] v);
    wr_aluop = a; wr_op1 = o1; wr_op2 = o2; regval = v;
    @(posedge clk); #1;
    wr_aluop = 1'b0; wr_op1 = 1'b0; wr_op2 = 1'b0; regval = '0;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    wb(1'b0, 1'b1, 1'b0, a);
    wb(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic op(input string name, input logic [2:0] code, input int lat,
                    input logic [2:0] ecsr, input logic [31:0] eop3);
    exp_t e;
    e.name  = name;
    e.val   = {ecsr, eop3};
    e.issue = cyc;
    e.due   = cyc + 1 + lat;
    sb.push_back(e);
    wb(1'b1, 1'b0, 1'b0, {29'h0, code});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain timeout: %0d results outstanding, want 0", sb.size());
      n_total++;
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle after reset", 64'(from_FU_to_DE), 64'h0);
    end
    @(posedge clk); #1;

    set_ops(32'd5, 32'd7);
    op("add 5+7", 3'd0, 1, 3'b010, 32'd12);
    drain();
    op("sub 5-7", 3'd1, 1, 3'b010, 32'hFFFF_FFFE);
    drain();

    set_ops(32'h0001_0000, 32'h0001_0000);
    op("mul 2^16*2^16", 3'd2, MUL_LAT, 3'b010, 32'h0);
    drain();
    set_ops(32'hFFFF_FFFF, 32'd2);
    op("mul ffffffff*2", 3'd2, MUL_LAT, 3'b010, 32'hFFFF_FFFE);
    drain();

    set_ops(32'd100, 32'd7);
    op("divu 100/7", 3'd3, DIV_LAT, 3'b010, 32'd14);
    drain();
    op("remu 100%7", 3'd4, DIV_LAT, 3'b010, 32'd2);
    drain();
    set_ops(32'd100, 32'd0);
    op("divu by 0", 3'd3, 1, 3'b110, 32'hFFFF_FFFF);
    drain();
    op("remu by 0", 3'd4, 1, 3'b110, 32'd100);
    drain();

    wb(1'b0, 1'b0, 1'b1, 32'd7);
    op("divu busy writes ignored", 3'd3, DIV_LAT, 3'b010, 32'd14);
    repeat (2) begin @(posedge clk); #1; end
    check("busy read shows old op3", 64'(from_FU_to_DE), {29'h0, 3'b001, 32'd100});
    wb(1'b0, 1'b1, 1'b0, 32'd9);
    wb(1'b1, 1'b0, 1'b0, 32'd0);
    drain();
    op("illegal aluop 6", 3'd6, 0, 3'b110, 32'd14);
    drain();
    op("add after ignored op1", 3'd0, 1, 3'b010, 32'd107);
    drain();

    op("divu aborted", 3'd3, DIV_LAT, 3'b010, 32'd14);
    sb.delete();
    repeat (5) begin @(posedge clk); #1; end
    pulse_reset();
    @(negedge clk);
    check("reset mid divu", 64'(from_FU_to_DE), 64'h0);
    @(posedge clk); #1;
    set_ops(32'd3, 32'd4);
    op("add after reset", 3'd0, 1, 3'b010, 32'd7);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
